// File: rtl/conv_dec.sv
// conv_dec: hard-decision Viterbi decoder for a rate-1/2 convolutional code with
// loadable generator masks, register-exchange survivors and saturating path metrics.
module conv_dec #(
  parameter int N = 4,
  parameter int D = 16,
  parameter int M = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   load_mask,
  input  logic [N-1:0] mask,
  input  logic         valid_in,
  input  logic [1:0]   sym_in,
  output logic         data_out,
  output logic         valid_out
);
  localparam int S  = 1 << (N - 1);
  localparam int CW = $clog2(D + 1);
  localparam logic [M-1:0]  PM_MAX   = '1;
  localparam logic [CW-1:0] CNT_FULL = CW'(D);
  localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

  logic [N-1:0]  mask0, mask1;
  logic [M-1:0]  pm        [S];
  logic [D-1:0]  surv      [S];
  logic [CW-1:0] cnt;

  logic [M-1:0]  cand      [S];
  logic [M-1:0]  pm_next   [S];
  logic [D-1:0]  surv_next [S];
  logic [M-1:0]  mn;
  logic          best_bit;

  function automatic logic [1:0] expected_sym(input logic [N-1:0] h,
                                              input logic [N-1:0] m0,
                                              input logic [N-1:0] m1);
    return {^(m1 & h), ^(m0 & h)};
  endfunction

  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ex);
    logic [1:0] d;
    d = rx ^ ex;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  function automatic logic [M-1:0] sat_add(input logic [M-1:0] a, input logic [1:0] bm);
    logic [M:0] sum;
    sum = {1'b0, a} + {{(M-1){1'b0}}, bm};
    return sum[M] ? PM_MAX : sum[M-1:0];
  endfunction

  // NOTE: masks are configuration, not trace state: no reset, and loads still
  // happen while the trellis is held in reset.
  always_ff @(posedge clk) begin
    if (load_mask[0]) mask0 <= mask;
    if (load_mask[1]) mask1 <= mask;
  end

  // Add-compare-select over every next state; ties keep the even predecessor.
  always_comb begin : acs
    logic [N-2:0] nsv, sp0, sp1;
    logic         b, sel, found;
    logic [M-1:0] c0, c1;
    // NOTE: every variable gets a default before the loops so no latch is
    // inferred; mn and found are running accumulators, hence blocking '='.
    nsv = '0; sp0 = '0; sp1 = '0;
    b = 1'b0; sel = 1'b0; found = 1'b0;
    c0 = '0; c1 = '0;
    mn = PM_MAX;
    best_bit = 1'b0;
    for (int ns = 0; ns < S; ns++) begin
      nsv = (N-1)'(ns);
      b   = nsv[N-2];
      sp0 = {nsv[N-3:0], 1'b0};
      sp1 = {nsv[N-3:0], 1'b1};
      c0  = sat_add(pm[sp0], branch_metric(sym_in, expected_sym({b, sp0}, mask0, mask1)));
      c1  = sat_add(pm[sp1], branch_metric(sym_in, expected_sym({b, sp1}, mask0, mask1)));
      sel = (c1 < c0);
      cand[ns]      = sel ? c1 : c0;
      surv_next[ns] = {(sel ? surv[sp1][D-2:0] : surv[sp0][D-2:0]), b};
      if (cand[ns] < mn) mn = cand[ns];
    end
    for (int ns = 0; ns < S; ns++) begin
      pm_next[ns] = cand[ns] - mn;
      if (!found && cand[ns] == mn) begin
        found    = 1'b1;
        best_bit = surv_next[ns][D-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < S; s++) begin
        pm[s]   <= (s == 0) ? '0 : PM_MAX;
        surv[s] <= '0;
      end
      cnt       <= '0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
    end else if (valid_in) begin
      for (int s = 0; s < S; s++) begin
        pm[s]   <= pm_next[s];
        surv[s] <= surv_next[s];
      end
      cnt       <= (cnt == CNT_FULL) ? cnt : cnt + 1'b1;
      valid_out <= (cnt >= CNT_LAST);
      data_out  <= best_bit;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule
